// File: rtl/mmss_timer_core.sv
// MM:SS stopwatch/countdown engine: debounced buttons, clamped preset load,
// BCD count-up/count-down and a blinking expiry alarm.
module mmss_timer_core #(
  parameter int unsigned TICK_DIV        = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_MINUTES     = 99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnR,
  input  logic        btnL,
  input  logic [15:0] switches_inputs,
  output logic [3:0]  sec_dig1,
  output logic [3:0]  sec_dig2,
  output logic [3:0]  min_dig1,
  output logic [3:0]  min_dig2,
  output logic        running,
  output logic        mode_down,
  output logic        done,
  output logic        alarm
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NBTN    = 3;
  localparam logic [3:0]  MAX_TENS  = 4'(MAX_MINUTES / 10);
  localparam logic [3:0]  MAX_UNITS = 4'(MAX_MINUTES % 10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t state, state_n;

  logic [NBTN-1:0] btn_raw, sync1, sync2, level, level_d, pulse_c;
  logic [DB_W-1:0] db_cnt [NBTN];
  logic            start_p, load_p, mode_p;

  logic [PRESC_W-1:0] presc;
  logic               tick_c;
  logic               load_take;

  logic [3:0] ld_mt, ld_mu, ld_st, ld_su, mu_clamp;
  logic [7:0] ld_min;
  logic [3:0] up_mt, up_mu, up_st, up_su;
  logic [3:0] dn_mt, dn_mu, dn_st, dn_su;
  logic [3:0] mt_n, mu_n, st_n, su_n;
  logic       md_n, al_n, finish;
  logic       at_max, at_zero, at_one;

  assign btn_raw = {btnL, btnR, btnU};

  // Two-flop synchroniser and accepted-level history for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level_d <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
    end
  end

  // Accepted level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
      for (int i = 0; i < int'(NBTN); i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NBTN); i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign pulse_c = level & ~level_d;
  assign start_p = pulse_c[0];
  assign load_p  = pulse_c[1];
  assign mode_p  = pulse_c[2];

  assign tick_c = ((state == S_RUN) || (state == S_DONE)) &&
                  (presc == PRESC_W'(TICK_DIV - 1));

  // Prescaler runs in RUN/DONE, holds in PAUSE, clears in IDLE and on load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if ((state == S_IDLE) || load_take) begin
      presc <= '0;
    end else if ((state == S_RUN) || (state == S_DONE)) begin
      presc <= tick_c ? '0 : presc + PRESC_W'(1);
    end
  end

  // Preset clamping to a legal MM:SS value
  always_comb begin
    mu_clamp = (switches_inputs[11:8] > 4'd9) ? 4'd9 : switches_inputs[11:8];
    ld_su    = (switches_inputs[3:0]  > 4'd9) ? 4'd9 : switches_inputs[3:0];
    ld_st    = (switches_inputs[7:4]  > 4'd5) ? 4'd5 : switches_inputs[7:4];
    ld_min   = 8'(switches_inputs[15:12]) * 8'd10 + 8'(mu_clamp);
    if (ld_min > 8'(MAX_MINUTES)) begin
      ld_mt = MAX_TENS;
      ld_mu = MAX_UNITS;
    end else begin
      ld_mt = switches_inputs[15:12];
      ld_mu = mu_clamp;
    end
  end

  // BCD increment and decrement of the displayed value
  always_comb begin
    {up_mt, up_mu, up_st, up_su} = {min_dig2, min_dig1, sec_dig2, sec_dig1};
    {dn_mt, dn_mu, dn_st, dn_su} = {min_dig2, min_dig1, sec_dig2, sec_dig1};
    if (sec_dig1 != 4'd9) begin
      up_su = sec_dig1 + 4'd1;
    end else begin
      up_su = 4'd0;
      if (sec_dig2 != 4'd5) begin
        up_st = sec_dig2 + 4'd1;
      end else begin
        up_st = 4'd0;
        if (min_dig1 != 4'd9) begin
          up_mu = min_dig1 + 4'd1;
        end else begin
          up_mu = 4'd0;
          up_mt = min_dig2 + 4'd1;
        end
      end
    end
    if (sec_dig1 != 4'd0) begin
      dn_su = sec_dig1 - 4'd1;
    end else begin
      dn_su = 4'd9;
      if (sec_dig2 != 4'd0) begin
        dn_st = sec_dig2 - 4'd1;
      end else begin
        dn_st = 4'd5;
        if (min_dig1 != 4'd0) begin
          dn_mu = min_dig1 - 4'd1;
        end else begin
          dn_mu = 4'd9;
          dn_mt = min_dig2 - 4'd1;
        end
      end
    end
  end

  assign at_max  = (min_dig2 == MAX_TENS) && (min_dig1 == MAX_UNITS) &&
                   (sec_dig2 == 4'd5) && (sec_dig1 == 4'd9);
  assign at_zero = ({min_dig2, min_dig1, sec_dig2, sec_dig1} == 16'h0000);
  assign at_one  = ({min_dig2, min_dig1, sec_dig2, sec_dig1} == 16'h0001);

  // Next state and next outputs; button priority load > start > mode
  always_comb begin
    state_n   = state;
    {mt_n, mu_n, st_n, su_n} = {min_dig2, min_dig1, sec_dig2, sec_dig1};
    md_n      = mode_down;
    al_n      = alarm;
    load_take = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_p) begin
          load_take = 1'b1;
          {mt_n, mu_n, st_n, su_n} = {ld_mt, ld_mu, ld_st, ld_su};
        end else if (start_p) begin
          if (!(mode_down && at_zero)) state_n = S_RUN;
        end else if (mode_p) begin
          md_n = ~mode_down;
        end
      end
      S_RUN: begin
        if (tick_c) begin
          if (mode_down) begin
            finish = at_zero || at_one;
            if (!at_zero) {mt_n, mu_n, st_n, su_n} = {dn_mt, dn_mu, dn_st, dn_su};
          end else if (at_max) begin
            finish = 1'b1;
          end else begin
            {mt_n, mu_n, st_n, su_n} = {up_mt, up_mu, up_st, up_su};
          end
        end
        if (finish) state_n = S_DONE;
        else if (start_p) state_n = S_PAUSE;
      end
      S_PAUSE: begin
        if (load_p) begin
          load_take = 1'b1;
          {mt_n, mu_n, st_n, su_n} = {ld_mt, ld_mu, ld_st, ld_su};
          state_n = S_IDLE;
        end else if (start_p) begin
          state_n = S_RUN;
        end else if (mode_p) begin
          md_n = ~mode_down;
        end
      end
      S_DONE: begin
        if (load_p) begin
          load_take = 1'b1;
          {mt_n, mu_n, st_n, su_n} = {ld_mt, ld_mu, ld_st, ld_su};
          state_n = S_IDLE;
          al_n    = 1'b0;
        end else if (start_p) begin
          state_n = S_IDLE;
          al_n    = 1'b0;
        end else if (tick_c) begin
          al_n = ~alarm;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register with state-decoded registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      sec_dig1  <= 4'd0;
      sec_dig2  <= 4'd0;
      min_dig1  <= 4'd0;
      min_dig2  <= 4'd0;
      mode_down <= 1'b0;
      alarm     <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sec_dig1  <= su_n;
      sec_dig2  <= st_n;
      min_dig1  <= mu_n;
      min_dig2  <= mt_n;
      mode_down <= md_n;
      alarm     <= al_n;
      running   <= (state_n == S_RUN);
      done      <= (state_n == S_DONE);
    end
  end

endmodule

// File: doc/mmss_timer_core.md
Name: mmss_timer_core

Overview:
- Parametrised MM:SS stopwatch/countdown engine.
- Sits between the board buttons/switches and seven_segment_display_subsystem, and drives its sec_dig1/sec_dig2/min_dig1/min_dig2 inputs with BCD digits.
- Adds count-up and count-down modes, preset load from switches, pause/resume, debounced buttons and an expiry alarm.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per count tick (1 Hz at 100 MHz); must be ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronised samples required to accept a button level; must be ≥ 1.
- MAX_MINUTES, 99: upper minute limit for loads and count-up, range 1..99.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btnU  in  1  start/pause/acknowledge button (raw)
- btnR  in  1  load-preset button (raw)
- btnL  in  1  mode-toggle button (raw)
- switches_inputs  in  16  BCD preset [15:12]=min tens, [11:8]=min units, [7:4]=sec tens, [3:0]=sec units
- sec_dig1  out  4  seconds units BCD
- sec_dig2  out  4  seconds tens BCD
- min_dig1  out  4  minutes units BCD
- min_dig2  out  4  minutes tens BCD
- running  out  1  high in RUN
- mode_down  out  1  1 = countdown, 0 = count-up
- done  out  1  high in DONE
- alarm  out  1  blinks while in DONE

Behaviour:
- Reset (async, active-high):
  - state IDLE; all digits 0; mode_down=0; running=done=alarm=0.
  - Prescaler, debouncers and edge detectors are cleared.
- Button path, per button:
  - 2-FF synchroniser.
  - Debounce counter: the accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - Rising-edge detect on the accepted level gives a 1-cycle pulse.
  - Press-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1 clocks.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN and DONE; holds its value in PAUSE.
  - Cleared in IDLE and on load.
  - tick = 1-cycle pulse when the count equals TICK_DIV-1.
  - Digits update on the clock edge that samples tick.
- State machine (IDLE, RUN, PAUSE, DONE):
  - IDLE:
    - start → RUN, except when mode_down=1 and the value is 00:00 (stays in IDLE).
    - mode toggles mode_down.
    - load captures the preset.
  - RUN:
    - On tick, step the count.
    - start → PAUSE.
    - load and mode are ignored.
  - PAUSE:
    - start → RUN, resuming with the held prescaler.
    - load → captures the preset, goes to IDLE.
    - mode toggles mode_down and stays in PAUSE.
  - DONE:
    - Digits frozen; alarm toggles on each tick.
    - start → IDLE (digits kept, alarm=0).
    - load → captures the preset, goes to IDLE, alarm=0.
    - mode is ignored.
- Simultaneous pulses in one cycle: priority is load > start > mode. Lower-priority pulses are dropped, and only pulses legal in the current state count.
- Load clamping:
  - Each unit digit > 9 clamps to 9.
  - Seconds tens > 5 clamps to 5.
  - A minute value > MAX_MINUTES clamps to MAX_MINUTES.
- Count-up step:
  - Seconds units wrap 9→0 and carry; seconds tens wrap 5→0 and carry into BCD minutes.
  - Tick at MAX_MINUTES:59 → no change, go to DONE.
  - Reaching MAX_MINUTES:59 by increment stays in RUN until the next tick.
- Count-down step:
  - Borrow is the mirror image of count-up carry (00→59 on seconds, borrowing one minute).
  - The tick that produces 00:00 also enters DONE on the same edge.
- Outputs:
  - Registered; running, done and mode_down are state-decoded registers.
  - Digits are always valid BCD (seconds tens ≤ 5, minutes ≤ MAX_MINUTES).

Test Plan (TICK_DIV=10, DEBOUNCE_CYCLES=4, MAX_MINUTES=99):
- Bounce: btnU toggling every 2 clocks for 20 clocks, then held high → exactly one start pulse, 7 clocks after the stable edge; running=1.
- Preset 0x0105 + btnR, btnL, btnU in countdown → 01:05, 01:04 … 00:00 after 65 ticks (650 clocks). done=1 on the edge of the last tick; alarm toggles every 10 clocks. btnU → IDLE, alarm=0, digits 00:00.
- Count-up from 00:59 → 01:00 on the next tick. Preset 99:58 → 99:59 → DONE on the following tick; digits held.
- Preset 0x9A7C → loaded value 99:59 (units clamped to 9, seconds tens clamped to 5); 0x6000 with MAX_MINUTES=30 → 30:00.
- Pause at prescaler count 6, wait 50 clocks, resume → next tick 4 clocks after resume. btnR during RUN is ignored; btnR during PAUSE → IDLE with the new preset.
- Assert reset mid-RUN (asynchronous, between edges) → all outputs are 0 immediately. Also: btnR and btnU pulses in the same cycle in IDLE → load only, state stays IDLE.
